lantian_mdio_master: RTL

Parametrised MDIO (IEEE 802.3 Clause 22) management master with a non-blocking Avalon-MM CSR slave. Software posts a command (op, PHY address, register address, write data), polls or takes an interrupt, then reads back the captured data. The frame includes a configurable preamble, and the PHY address is runtime-selectable. It sits between the Nios Avalon fabric and the Ethernet PHY MDC/MDIO pins; the top-level tristate buffer uses mdio_out/mdio_oen.

---
 rtl/lantian_mdio_master.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lantian_mdio_master.sv
// rtl/lantian_mdio_master.sv - MDIO (Clause 22) management master with Avalon-MM CSR slave
//
// Purpose:
//   Software posts a command through CMD (op, PHY address, register address,
//   write data, go).  The block runs a preamble + 32-bit management frame on
//   MDC/MDIO, captures read data, then flags STATUS.done (optionally as irq).
//
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   avs_address/read/readdata/write/writedata
//                       CSR slave, registered read data (latency 1), no waitrequest
//   irq                 level interrupt, STATUS.done & CONFIG.irq_en
//   mdc                 management clock, low while idle
//   mdio_in             pad input
//   mdio_out, mdio_oen  pad drive value and active-low output enable
//
// Build option:
//   MDIO_CLAUSE45_EN    CMD[29:28] selects ST; ST=00 runs Clause 45 frames.
//
// CSR map:
//   0 CMD     [15:0] wdata [20:16] regad [25:21] phyad [27:26] op [31] go
//   1 STATUS  [0] busy [1] done (W1C) [2] overrun (W1C) [3] bad_op (W1C)
//   2 RDATA   [15:0] last read data
//   3 CONFIG  [0] irq_en

`timescale 1ns/1ps

module lantian_mdio_master #(
    parameter int CLK_DIV      = 40,
    parameter int PREAMBLE_LEN = 32,
    parameter bit IRQ_DEFAULT  = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        irq,
    output logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRE   = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;
    localparam logic [1:0] S_TAIL  = 2'd3;

    // Phase counter positions inside one bit period.
    localparam logic [6:0] PH_LAST = 7'(CLK_DIV - 1);
    localparam logic [6:0] PH_HIGH = 7'(CLK_DIV / 2);
    localparam logic [6:0] PH_RISE = 7'(CLK_DIV / 2 - 1);
    localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [6:0]  phase;
    logic [5:0]  bit_cnt;
    logic [31:0] shreg;
    logic        read_q;
    logic [15:0] rd_shift;
    logic [15:0] rdata;

    logic [15:0] cmd_wdata;
    logic [4:0]  cmd_regad;
    logic [4:0]  cmd_phyad;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_st;

    logic        busy;
    logic        done;
    logic        overrun;
    logic        bad_op;
    logic        irq_en;

    // ------------------------------------------------------------------
    // CSR write decode
    // ------------------------------------------------------------------
    logic        cmd_wr;
    logic        status_wr;
    logic        config_wr;
    logic        go_w;
    logic [1:0]  op_w;
    logic [1:0]  st_w;
    logic        legal_w;
    logic        is_read_w;
    logic        start;
    logic [31:0] frame_word;
    logic        unused_wd;

    assign cmd_wr    = avs_write && (avs_address == 2'd0);
    assign status_wr = avs_write && (avs_address == 2'd1);
    assign config_wr = avs_write && (avs_address == 2'd3);
    assign go_w      = avs_writedata[31];
    assign op_w      = avs_writedata[27:26];

`ifdef MDIO_CLAUSE45_EN
    // ST=00 is Clause 45 where every op code is legal and ops 1x read;
    // ST=01 keeps Clause 22 rules; other ST values are rejected.
    assign st_w      = avs_writedata[29:28];
    assign legal_w   = (st_w == 2'b00) ||
                       ((st_w == 2'b01) && ((op_w == 2'b01) || (op_w == 2'b10)));
    assign is_read_w = (st_w == 2'b00) ? op_w[1] : (op_w == 2'b10);
    assign unused_wd = avs_writedata[30];
`else
    assign st_w      = 2'b01;
    assign legal_w   = (op_w == 2'b01) || (op_w == 2'b10);
    assign is_read_w = (op_w == 2'b10);
    assign unused_wd = ^avs_writedata[30:28];
`endif

    assign start = cmd_wr && go_w && !busy && legal_w;

    // Read frames leave TA and data undriven; the shift register content
    // there is don't-care because mdio_out is forced low while released.
    assign frame_word = {st_w, op_w, avs_writedata[25:21], avs_writedata[20:16],
                         (is_read_w ? 2'b11 : 2'b10),
                         (is_read_w ? 16'h0000 : avs_writedata[15:0])};

    // ------------------------------------------------------------------
    // Frame sequencer next-state
    // ------------------------------------------------------------------
    logic [1:0]  state_d;
    logic [6:0]  phase_d;
    logic [5:0]  bit_d;
    logic [31:0] shreg_d;
    logic        read_d;
    logic        frame_end;
    logic        tail_end;

    always_comb begin
        state_d   = state;
        phase_d   = phase;
        bit_d     = bit_cnt;
        shreg_d   = shreg;
        read_d    = read_q;
        frame_end = 1'b0;
        tail_end  = 1'b0;
        if (start) begin
            state_d = (PREAMBLE_LEN == 0) ? S_FRAME : S_PRE;
            phase_d = 7'd0;
            bit_d   = 6'd0;
            shreg_d = frame_word;
            read_d  = is_read_w;
        end else if (state != S_IDLE) begin
            if (phase == PH_LAST) begin
                phase_d = 7'd0;
                bit_d   = bit_cnt + 6'd1;
                case (state)
                    S_PRE: begin
                        if (bit_cnt == PRE_LAST) begin
                            state_d = S_FRAME;
                            bit_d   = 6'd0;
                        end
                    end
                    S_FRAME: begin
                        shreg_d = {shreg[30:0], 1'b0};
                        if (bit_cnt == 6'd31) begin
                            state_d   = S_TAIL;
                            bit_d     = 6'd0;
                            frame_end = 1'b1;
                        end
                    end
                    default: begin
                        state_d  = S_IDLE;
                        tail_end = 1'b1;
                    end
                endcase
            end else begin
                phase_d = phase + 7'd1;
            end
        end
    end

    // Pad outputs are registered from the next-state view so they only move
    // when a new bit period starts (MDC falling edge).
    logic mdc_d;
    logic out_d;
    logic oen_d;

    always_comb begin
        mdc_d = 1'b0;
        out_d = 1'b0;
        oen_d = 1'b1;
        case (state_d)
            S_PRE: begin
                mdc_d = (phase_d >= PH_HIGH);
                out_d = 1'b1;
                oen_d = 1'b0;
            end
            S_FRAME: begin
                mdc_d = (phase_d >= PH_HIGH);
                oen_d = read_d && (bit_d >= 6'd14);
                out_d = !oen_d && shreg_d[31];
            end
            default: begin
                mdc_d = 1'b0;
                out_d = 1'b0;
                oen_d = 1'b1;
            end
        endcase
    end

    // Sample on the clk edge that raises MDC, during the 16 data bits.
    logic capture;
    assign capture = (state == S_FRAME) && read_q && (bit_cnt >= 6'd16) &&
                     (phase == PH_RISE);

    // ------------------------------------------------------------------
    // CSR read mux
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = 32'h0;
        case (avs_address)
            2'd0: rd_mux = {2'b00, cmd_st, cmd_op, cmd_phyad, cmd_regad, cmd_wdata};
            2'd1: rd_mux = {28'h0, bad_op, overrun, done, busy};
            2'd2: rd_mux = {16'h0, rdata};
            default: rd_mux = {31'h0, irq_en};
        endcase
    end

    assign irq = done && irq_en;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            phase        <= 7'd0;
            bit_cnt      <= 6'd0;
            shreg        <= 32'h0;
            read_q       <= 1'b0;
            rd_shift     <= 16'h0;
            rdata        <= 16'h0;
            mdc          <= 1'b0;
            mdio_out     <= 1'b0;
            mdio_oen     <= 1'b1;
            avs_readdata <= 32'h0;
        end else begin
            state    <= state_d;
            phase    <= phase_d;
            bit_cnt  <= bit_d;
            shreg    <= shreg_d;
            read_q   <= read_d;
            mdc      <= mdc_d;
            mdio_out <= out_d;
            mdio_oen <= oen_d;
            if (capture) begin
                rd_shift <= {rd_shift[14:0], mdio_in};
            end
            if (frame_end && read_q) begin
                rdata <= rd_shift;
            end
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_wdata <= 16'h0;
            cmd_regad <= 5'h0;
            cmd_phyad <= 5'h0;
            cmd_op    <= 2'b00;
            cmd_st    <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            bad_op    <= 1'b0;
            irq_en    <= IRQ_DEFAULT;
        end else begin
            // Fields are frozen while a frame is in flight.
            if (cmd_wr && !busy) begin
                cmd_wdata <= avs_writedata[15:0];
                cmd_regad <= avs_writedata[20:16];
                cmd_phyad <= avs_writedata[25:21];
                cmd_op    <= op_w;
`ifdef MDIO_CLAUSE45_EN
                cmd_st    <= st_w;
`endif
            end

            if (start) begin
                busy <= 1'b1;
            end else if (tail_end) begin
                busy <= 1'b0;
            end

            // Hardware sets take priority over a same-cycle W1C.
            if (tail_end) begin
                done <= 1'b1;
            end else if (status_wr && avs_writedata[1]) begin
                done <= 1'b0;
            end

            if (cmd_wr && go_w && busy) begin
                overrun <= 1'b1;
            end else if (status_wr && avs_writedata[2]) begin
                overrun <= 1'b0;
            end

            if (cmd_wr && go_w && !busy && !legal_w) begin
                bad_op <= 1'b1;
            end else if (status_wr && avs_writedata[3]) begin
                bad_op <= 1'b0;
            end

            if (config_wr) begin
                irq_en <= avs_writedata[0];
            end
        end
    end

endmodule
